cw_mac_engine: RTL and testbench
================================

# cw_mac_engine

Parametrised Carter-Wegman MAC engine, successor to the fixed 512-bit/56-bit CWMAC block in the memory-protection path.
- Hashes one message per request with an iterative NH universal hash, one 64-bit lane per cycle.
- Obtains a one-time pad for (addr, nonce) from an external block-cipher core over a request/response handshake, and emits tag = low TAG_W bits of (hash + pad).
- Adds ready/valid back-pressure on both sides and a verify mode that compares against a supplied tag and reports pass/fail.

## Interface
Parameters:
- MSG_W, 512: message and hash-key width; multiple of 64.
- TAG_W, 56: tag width; 1..64.
- ADDR_W, 26: address width.
- NONCE_W, 56: nonce width.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- io_source_valid / io_source_ready  in / out  1  request handshake.
- io_source_bits_addr  in  ADDR_W  block address.
- io_source_bits_nonce  in  NONCE_W  write counter.
- io_source_bits_msg  in  MSG_W  message.
- io_source_bits_verify  in  1  1 = compare against the expected tag.
- io_source_bits_expTag  in  TAG_W  expected tag; used only when verify = 1.
- io_keyHash  in  MSG_W  NH key; must be stable while busy.
- io_pad_req_valid / io_pad_req_ready  out / in  1  pad-request handshake to the cipher.
- io_pad_req_bits  out  ADDR_W+NONCE_W  {addr, nonce}.
- io_pad_resp_valid  in  1  pad valid; the cipher cannot be stalled.
- io_pad_resp_bits  in  128  pad; only bits [63:0] are used.
- io_tag_valid / io_tag_ready  out / in  1  result handshake.
- io_tag_bits  out  TAG_W  computed tag.
- io_tag_match  out  1  verify result; 0 when verify = 0.

## Operation
- Lane count: N = MSG_W/64.
- Word definitions: word j = msg[32j+31:32j]; kword j = keyHash[32j+31:32j].
- Hash: acc = sum over i = 0..N-1 of ((word 2i + kword 2i) mod 2^32) × ((word 2i+1 + kword 2i+1) mod 2^32), accumulated mod 2^64.
- Tag: tag = (acc + pad[63:0]) mod 2^64, truncated to [TAG_W-1:0].
- Match: match = verify & (tag == expTag).
- IDLE: io_source_ready = 1. On fire, latch msg, addr, nonce, verify and expTag; clear acc, lane counter, pad_req_done and pad_got; go to HASH.
- HASH: one lane per cycle, lane counter 0..N-1. After lane N-1 go to WAIT_PAD, or straight to OUT if pad_got is already set.
- Pad request, in parallel with HASH and WAIT_PAD: io_pad_req_valid is high from the cycle after accept until req fire, then sets pad_req_done. It is issued exactly once per message.
- Pad response: when io_pad_resp_valid arrives after pad_req_done, latch the pad and set pad_got. A response arriving in the same cycle as the last hash lane is captured.
- WAIT_PAD: on pad_got, go to OUT. No timeout.
- OUT: io_tag_valid = 1; tag and match are registered and held stable until io_tag_ready. On fire go to IDLE.
- io_source_ready is 0 in every state except IDLE. No pipelining: one message in flight.
- io_pad_resp_valid while pad_req_done = 0 (spurious) is ignored.

## Timing
- Reset values: io_source_ready = 1, io_pad_req_valid = 0, io_tag_valid = 0, io_tag_bits = 0, io_tag_match = 0, state = IDLE, acc = 0.
- Reset mid-operation abandons the message. The cipher owner must flush any in-flight pad.
- Accept is at cycle 0. HASH runs in cycles 1..N.
- Minimum latency: if the pad arrives at or before cycle N, io_tag_valid rises at cycle N+1 (9 for MSG_W = 512).
- If the pad arrives later, at cycle P > N, tag_valid rises at P+1.
- Back-to-back: with tag_ready = 1, io_source_ready returns to 1 in the cycle after tag fire. Throughput is one message per N+2 cycles.

## Structure
- Shared package cwmac_pkg: NH_LANE_W = 64, PAD_W = 128, state enum {IDLE, HASH, WAIT_PAD, OUT}, and an nh_lane function (two 32-bit adds and a 32×32 multiply).
- Natural sub-module: cwmac_nh_acc, holding the lane counter and the 64-bit accumulator, with start/step/done outputs.

## Test plan
- msg = 0, key = 0, pad = 0x…123456789ABCDEF0 returned at cycle 3 → tag = 0x3456789ABCDEF0 at cycle 9; match = 0.
- word0 = 2, word1 = 3, all other words 0, key = 0, pad = 0 → tag = 0x6.
- word0 = 0xFFFFFFFF, kword0 = 1, word1 = 5, key otherwise 0, pad = 0 → the 32-bit sum wraps to 0, so tag = 0. Then verify = 1 with expTag = 0 → match = 1; expTag = 1 → match = 0.
- pad_req_ready held low 20 cycles, pad returned 5 cycles after req fire → exactly one req fire; tag_valid one cycle after pad.
- tag_ready held low 10 cycles → tag bits stable and source_ready = 0 throughout. Then back-to-back second message accepted the cycle after fire.
- reset asserted in cycle 4 of HASH → all outputs return to reset values asynchronously. A following fresh message produces the correct tag.

Source files
------------

// File: rtl/cwmac_pkg.sv
// Shared types and the NH lane primitive for the Carter-Wegman MAC engine.
package cwmac_pkg;

    localparam int unsigned NH_LANE_W = 64;
    localparam int unsigned PAD_W     = 128;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HASH     = 2'd1,
        WAIT_PAD = 2'd2,
        OUT      = 2'd3
    } state_e;

    // One NH lane: two 32-bit word+key sums (wrapping), multiplied to 64 bits.
    function automatic logic [63:0] nh_lane(input logic [63:0] m, input logic [63:0] k);
        logic [31:0] lo;
        logic [31:0] hi;
        lo = m[31:0] + k[31:0];
        hi = m[63:32] + k[63:32];
        return 64'(lo) * 64'(hi);
    endfunction

endpackage

// File: rtl/cwmac_nh_acc.sv
// Iterative NH accumulator: one 64-bit lane per step, lane counter and 64-bit sum.
module cwmac_nh_acc
    import cwmac_pkg::*;
#(
    parameter int unsigned MSG_W = 512
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             step,
    input  logic [MSG_W-1:0] msg,
    input  logic [MSG_W-1:0] key,
    output logic [63:0]      acc,
    output logic [63:0]      acc_next_c,
    output logic             done_c
);

    localparam int unsigned N     = MSG_W / NH_LANE_W;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    logic [CNT_W-1:0]                lane;
    logic [N-1:0][NH_LANE_W-1:0]     msg_lanes;
    logic [N-1:0][NH_LANE_W-1:0]     key_lanes;

    assign msg_lanes  = msg;
    assign key_lanes  = key;
    assign acc_next_c = acc + nh_lane(msg_lanes[lane], key_lanes[lane]);
    assign done_c     = step && (lane == CNT_W'(N - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc  <= '0;
            lane <= '0;
        end else if (start) begin
            acc  <= '0;
            lane <= '0;
        end else if (step) begin
            acc  <= acc_next_c;
            lane <= lane + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cw_mac_engine.sv
// Carter-Wegman MAC: iterative NH hash plus a cipher-supplied one-time pad,
// with ready/valid on request, pad and tag sides and an optional tag compare.
module cw_mac_engine
    import cwmac_pkg::*;
#(
    parameter int unsigned MSG_W   = 512,
    parameter int unsigned TAG_W   = 56,
    parameter int unsigned ADDR_W  = 26,
    parameter int unsigned NONCE_W = 56
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      io_source_valid,
    output logic                      io_source_ready,
    input  logic [ADDR_W-1:0]         io_source_bits_addr,
    input  logic [NONCE_W-1:0]        io_source_bits_nonce,
    input  logic [MSG_W-1:0]          io_source_bits_msg,
    input  logic                      io_source_bits_verify,
    input  logic [TAG_W-1:0]          io_source_bits_expTag,
    input  logic [MSG_W-1:0]          io_keyHash,
    output logic                      io_pad_req_valid,
    input  logic                      io_pad_req_ready,
    output logic [ADDR_W+NONCE_W-1:0] io_pad_req_bits,
    input  logic                      io_pad_resp_valid,
    input  logic [PAD_W-1:0]          io_pad_resp_bits,
    output logic                      io_tag_valid,
    input  logic                      io_tag_ready,
    output logic [TAG_W-1:0]          io_tag_bits,
    output logic                      io_tag_match
);

    state_e             state;
    state_e             state_next;
    logic               source_fire;
    logic               req_fire;
    logic               tag_fire;
    logic               pad_take_c;
    logic               pad_avail_c;
    logic               load_tag_c;
    logic               hash_start_c;
    logic               hash_step_c;
    logic               hash_done_c;
    logic               req_done;
    logic               pad_got;
    logic               verify_q;
    logic [TAG_W-1:0]   exp_tag_q;
    logic [MSG_W-1:0]   msg_q;
    logic [63:0]        pad_q;
    logic [63:0]        acc;
    logic [63:0]        acc_next_c;
    logic [63:0]        pad_val_c;
    logic [63:0]        tag_sum_c;
    logic [TAG_W-1:0]   tag_c;
    logic               unused_pad_hi;

    assign unused_pad_hi = ^io_pad_resp_bits[PAD_W-1:64];

    assign source_fire = io_source_valid && io_source_ready;
    assign req_fire    = io_pad_req_valid && io_pad_req_ready;
    assign tag_fire    = io_tag_valid && io_tag_ready;

    // Only the first response after our request is taken; anything earlier is spurious.
    assign pad_take_c  = io_pad_resp_valid && req_done && !pad_got &&
                         ((state == HASH) || (state == WAIT_PAD));
    assign pad_avail_c = pad_got || pad_take_c;
    assign pad_val_c   = pad_got ? pad_q : io_pad_resp_bits[63:0];

    // In HASH the final lane is still being summed, so use the combinational total.
    assign tag_sum_c   = ((state == HASH) ? acc_next_c : acc) + pad_val_c;
    assign tag_c       = tag_sum_c[TAG_W-1:0];

    cwmac_nh_acc #(
        .MSG_W (MSG_W)
    ) u_nh_acc (
        .clock      (clock),
        .reset      (reset),
        .start      (hash_start_c),
        .step       (hash_step_c),
        .msg        (msg_q),
        .key        (io_keyHash),
        .acc        (acc),
        .acc_next_c (acc_next_c),
        .done_c     (hash_done_c)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        hash_start_c = 1'b0;
        hash_step_c  = 1'b0;
        load_tag_c   = 1'b0;
        case (state)
            IDLE: begin
                if (source_fire) begin
                    state_next   = HASH;
                    hash_start_c = 1'b1;
                end
            end
            HASH: begin
                hash_step_c = 1'b1;
                if (hash_done_c) begin
                    state_next = pad_avail_c ? OUT : WAIT_PAD;
                    load_tag_c = pad_avail_c;
                end
            end
            WAIT_PAD: begin
                if (pad_take_c) begin
                    state_next = OUT;
                    load_tag_c = 1'b1;
                end
            end
            OUT: begin
                if (io_tag_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request latch, pad handshake bookkeeping and registered tag outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            io_source_ready  <= 1'b1;
            io_pad_req_valid <= 1'b0;
            io_pad_req_bits  <= '0;
            io_tag_valid     <= 1'b0;
            io_tag_bits      <= '0;
            io_tag_match     <= 1'b0;
            req_done         <= 1'b0;
            pad_got          <= 1'b0;
            pad_q            <= '0;
            verify_q         <= 1'b0;
            exp_tag_q        <= '0;
            msg_q            <= '0;
        end else begin
            if (source_fire) begin
                io_source_ready  <= 1'b0;
                io_pad_req_valid <= 1'b1;
                io_pad_req_bits  <= {io_source_bits_addr, io_source_bits_nonce};
                msg_q            <= io_source_bits_msg;
                verify_q         <= io_source_bits_verify;
                exp_tag_q        <= io_source_bits_expTag;
                req_done         <= 1'b0;
                pad_got          <= 1'b0;
            end
            if (req_fire) begin
                io_pad_req_valid <= 1'b0;
                req_done         <= 1'b1;
            end
            if (pad_take_c) begin
                pad_q   <= io_pad_resp_bits[63:0];
                pad_got <= 1'b1;
            end
            if (load_tag_c) begin
                io_tag_valid <= 1'b1;
                io_tag_bits  <= tag_c;
                io_tag_match <= verify_q && (tag_c == exp_tag_q);
            end
            if (tag_fire) begin
                io_tag_valid    <= 1'b0;
                io_source_ready <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cw_mac_engine.sv
// Self-checking bench for cw_mac_engine against an arithmetic NH/Carter-Wegman model.
module tb_cw_mac_engine;

    localparam int unsigned MSG_W   = 512;
    localparam int unsigned TAG_W   = 56;
    localparam int unsigned ADDR_W  = 26;
    localparam int unsigned NONCE_W = 56;
    localparam int          N       = MSG_W / 64;

    logic                      clock = 1'b0;
    logic                      reset = 1'b1;
    logic                      io_source_valid = 1'b0;
    logic                      io_source_ready;
    logic [ADDR_W-1:0]         io_source_bits_addr = '0;
    logic [NONCE_W-1:0]        io_source_bits_nonce = '0;
    logic [MSG_W-1:0]          io_source_bits_msg = '0;
    logic                      io_source_bits_verify = 1'b0;
    logic [TAG_W-1:0]          io_source_bits_expTag = '0;
    logic [MSG_W-1:0]          io_keyHash = '0;
    logic                      io_pad_req_valid;
    logic                      io_pad_req_ready = 1'b0;
    logic [ADDR_W+NONCE_W-1:0] io_pad_req_bits;
    logic                      io_pad_resp_valid = 1'b0;
    logic [127:0]              io_pad_resp_bits = '0;
    logic                      io_tag_valid;
    logic                      io_tag_ready = 1'b0;
    logic [TAG_W-1:0]          io_tag_bits;
    logic                      io_tag_match;

    int checks = 0;
    int errors = 0;

    // Observations from the most recent transaction
    logic [TAG_W-1:0] r_tag;
    logic             r_match;
    int               r_vc;
    int               r_fires;
    int               r_fc;
    int               r_pc;
    bit               r_acc_ok;
    bit               r_hold_ok;
    bit               r_bits_ok;
    bit               r_to;

    always #5 clock = ~clock;

    cw_mac_engine #(
        .MSG_W(MSG_W), .TAG_W(TAG_W), .ADDR_W(ADDR_W), .NONCE_W(NONCE_W)
    ) dut (
        .clock                 (clock),
        .reset                 (reset),
        .io_source_valid       (io_source_valid),
        .io_source_ready       (io_source_ready),
        .io_source_bits_addr   (io_source_bits_addr),
        .io_source_bits_nonce  (io_source_bits_nonce),
        .io_source_bits_msg    (io_source_bits_msg),
        .io_source_bits_verify (io_source_bits_verify),
        .io_source_bits_expTag (io_source_bits_expTag),
        .io_keyHash            (io_keyHash),
        .io_pad_req_valid      (io_pad_req_valid),
        .io_pad_req_ready      (io_pad_req_ready),
        .io_pad_req_bits       (io_pad_req_bits),
        .io_pad_resp_valid     (io_pad_resp_valid),
        .io_pad_resp_bits      (io_pad_resp_bits),
        .io_tag_valid          (io_tag_valid),
        .io_tag_ready          (io_tag_ready),
        .io_tag_bits           (io_tag_bits),
        .io_tag_match          (io_tag_match)
    );

    // NH as a plain sum of products over 32-bit word pairs
    function automatic logic [63:0] ref_hash(input logic [MSG_W-1:0] m, input logic [MSG_W-1:0] k);
        logic [63:0] s;
        logic [31:0] a;
        logic [31:0] b;
        s = 64'd0;
        for (int i = 0; i < N; i++) begin
            a = m[64*i +: 32] + k[64*i +: 32];
            b = m[64*i+32 +: 32] + k[64*i+32 +: 32];
            s = s + 64'(a) * 64'(b);
        end
        return s;
    endfunction

    function automatic logic [TAG_W-1:0] ref_tag(input logic [MSG_W-1:0] m, input logic [MSG_W-1:0] k,
                                                input logic [63:0] pad);
        logic [63:0] t;
        t = ref_hash(m, k) + pad;
        return t[TAG_W-1:0];
    endfunction

    function automatic logic [MSG_W-1:0] rand_vec();
        logic [MSG_W-1:0] v;
        for (int i = 0; i < MSG_W / 32; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Drives one message through all three handshakes; call at a falling edge.
    task automatic do_txn(input logic [MSG_W-1:0] m, input logic [MSG_W-1:0] k, input logic vfy,
                          input logic [TAG_W-1:0] et, input logic [63:0] pad, input int req_hold,
                          input int pad_gap, input int tag_hold, input bit spurious);
        int c;
        bit got;
        bit done;
        logic [ADDR_W-1:0]  a;
        logic [NONCE_W-1:0] n;
        a = ADDR_W'($urandom);
        n = NONCE_W'({$urandom, $urandom});
        r_acc_ok = (io_source_ready === 1'b1);
        r_fires = 0; r_fc = -1; r_pc = -1; r_vc = -1;
        r_hold_ok = 1'b1; r_bits_ok = 1'b1; r_to = 1'b0;
        r_tag = '0; r_match = 1'b0;
        io_keyHash            = k;
        io_source_valid       = 1'b1;
        io_source_bits_msg    = m;
        io_source_bits_addr   = a;
        io_source_bits_nonce  = n;
        io_source_bits_verify = vfy;
        io_source_bits_expTag = et;
        io_pad_req_ready      = (req_hold == 0);
        c = 0; got = 1'b0; done = 1'b0;
        while (!done) begin
            @(negedge clock);
            c++;
            io_source_valid    = 1'b0;
            io_source_bits_msg = ~m;
            io_source_bits_expTag = ~et;
            if (c > 400) begin
                r_to = 1'b1;
                break;
            end
            io_pad_req_ready = (c > req_hold);
            if (io_pad_req_valid === 1'b1 && io_pad_req_ready) begin
                r_fires++;
                if (r_fc < 0) begin
                    r_fc = c;
                    r_pc = c + pad_gap;
                end
                if (io_pad_req_bits !== {a, n}) r_bits_ok = 1'b0;
            end
            io_pad_resp_bits  = {$urandom, $urandom, $urandom, $urandom};
            io_pad_resp_valid = 1'b0;
            if (c == r_pc) begin
                io_pad_resp_valid      = 1'b1;
                io_pad_resp_bits[63:0] = pad;
            end else if (spurious && c == 1) begin
                io_pad_resp_valid = 1'b1;
            end
            if (io_source_ready !== 1'b0) r_hold_ok = 1'b0;
            if (got) begin
                if (io_tag_valid !== 1'b1 || io_tag_bits !== r_tag || io_tag_match !== r_match)
                    r_hold_ok = 1'b0;
            end else if (io_tag_valid === 1'b1) begin
                got = 1'b1;
                r_vc = c;
                r_tag = io_tag_bits;
                r_match = io_tag_match;
            end
            io_tag_ready = got && (c >= r_vc + tag_hold);
            if (io_tag_ready && io_tag_valid === 1'b1) done = 1'b1;
        end
        @(negedge clock);
        io_tag_ready      = 1'b0;
        io_pad_resp_valid = 1'b0;
        io_pad_req_ready  = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        checks++; if (io_source_ready !== 1'b1) begin errors++; $display("FAIL reset_source_ready: got %b want 1", io_source_ready); end
        checks++; if (io_pad_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", io_pad_req_valid); end
        checks++; if (io_tag_valid !== 1'b0) begin errors++; $display("FAIL reset_tag_valid: got %b want 0", io_tag_valid); end
        checks++; if (io_tag_bits !== '0) begin errors++; $display("FAIL reset_tag_bits: got %h want 0", io_tag_bits); end
        checks++; if (io_tag_match !== 1'b0) begin errors++; $display("FAIL reset_tag_match: got %b want 0", io_tag_match); end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_zero_msg_pad();
        do_txn('0, '0, 1'b0, '0, 64'h1234_5678_9ABC_DEF0, 0, 2, 0, 1'b0);
        checks++; if (r_to) begin errors++; $display("FAIL zero_timeout: got timeout want tag"); end
        checks++; if (r_tag !== 56'h34_5678_9ABC_DEF0) begin errors++; $display("FAIL zero_tag: got %h want 3456789abcdef0", r_tag); end
        checks++; if (r_match !== 1'b0) begin errors++; $display("FAIL zero_match: got %b want 0", r_match); end
        checks++; if (r_vc !== N + 1) begin errors++; $display("FAIL zero_latency: got %0d want %0d", r_vc, N + 1); end
        checks++; if (r_fires !== 1) begin errors++; $display("FAIL zero_req_fires: got %0d want 1", r_fires); end
        checks++; if (!r_bits_ok) begin errors++; $display("FAIL zero_req_bits: got mismatch want {addr,nonce}"); end
        checks++; if (!r_acc_ok) begin errors++; $display("FAIL zero_accept: got source_ready 0 want 1"); end
    endtask

    task automatic test_small_words();
        logic [MSG_W-1:0] m;
        m = '0;
        m[31:0]  = 32'd2;
        m[63:32] = 32'd3;
        do_txn(m, '0, 1'b0, '0, 64'd0, 0, 1, 0, 1'b0);
        checks++; if (r_tag !== 56'd6) begin errors++; $display("FAIL small_tag: got %h want 6", r_tag); end
        checks++; if (r_vc !== N + 1) begin errors++; $display("FAIL small_latency: got %0d want %0d", r_vc, N + 1); end
    endtask

    task automatic test_wrap_verify();
        logic [MSG_W-1:0] m;
        logic [MSG_W-1:0] k;
        m = '0; k = '0;
        m[31:0]  = 32'hFFFF_FFFF;
        m[63:32] = 32'd5;
        k[31:0]  = 32'd1;
        do_txn(m, k, 1'b0, '0, 64'd0, 0, 3, 0, 1'b0);
        checks++; if (r_tag !== 56'd0) begin errors++; $display("FAIL wrap_tag: got %h want 0", r_tag); end
        checks++; if (r_match !== 1'b0) begin errors++; $display("FAIL wrap_nomatch_noverify: got %b want 0", r_match); end
        do_txn(m, k, 1'b1, 56'd0, 64'd0, 0, 3, 0, 1'b0);
        checks++; if (r_match !== 1'b1) begin errors++; $display("FAIL wrap_verify_pass: got %b want 1", r_match); end
        do_txn(m, k, 1'b1, 56'd1, 64'd0, 0, 3, 0, 1'b0);
        checks++; if (r_match !== 1'b0) begin errors++; $display("FAIL wrap_verify_fail: got %b want 0", r_match); end
        checks++; if (r_tag !== 56'd0) begin errors++; $display("FAIL wrap_verify_tag: got %h want 0", r_tag); end
    endtask

    task automatic test_req_stall();
        logic [MSG_W-1:0] m;
        logic [MSG_W-1:0] k;
        logic [63:0]      pad;
        m = rand_vec(); k = rand_vec(); pad = {$urandom, $urandom};
        do_txn(m, k, 1'b0, '0, pad, 20, 5, 0, 1'b1);
        checks++; if (r_fires !== 1) begin errors++; $display("FAIL stall_req_fires: got %0d want 1", r_fires); end
        checks++; if (r_fc !== 21) begin errors++; $display("FAIL stall_req_cycle: got %0d want 21", r_fc); end
        checks++; if (r_vc !== 27) begin errors++; $display("FAIL stall_latency: got %0d want 27", r_vc); end
        checks++; if (r_tag !== ref_tag(m, k, pad)) begin errors++; $display("FAIL stall_tag: got %h want %h", r_tag, ref_tag(m, k, pad)); end
        checks++; if (!r_bits_ok) begin errors++; $display("FAIL stall_req_bits: got mismatch want {addr,nonce}"); end
    endtask

    task automatic test_back_to_back();
        logic [MSG_W-1:0] m;
        logic [MSG_W-1:0] k;
        logic [63:0]      pad;
        m = rand_vec(); k = rand_vec(); pad = {$urandom, $urandom};
        do_txn(m, k, 1'b0, '0, pad, 0, 1, 10, 1'b0);
        checks++; if (!r_hold_ok) begin errors++; $display("FAIL hold_stable: got changing outputs want stable"); end
        checks++; if (r_tag !== ref_tag(m, k, pad)) begin errors++; $display("FAIL hold_tag: got %h want %h", r_tag, ref_tag(m, k, pad)); end
        m = rand_vec(); pad = {$urandom, $urandom};
        do_txn(m, k, 1'b0, '0, pad, 0, 2, 0, 1'b0);
        checks++; if (!r_acc_ok) begin errors++; $display("FAIL b2b_accept: got source_ready 0 want 1"); end
        checks++; if (r_vc !== N + 1) begin errors++; $display("FAIL b2b_latency: got %0d want %0d", r_vc, N + 1); end
        checks++; if (r_tag !== ref_tag(m, k, pad)) begin errors++; $display("FAIL b2b_tag: got %h want %h", r_tag, ref_tag(m, k, pad)); end
    endtask

    task automatic test_mid_reset();
        logic [MSG_W-1:0] m;
        logic [MSG_W-1:0] k;
        logic [63:0]      pad;
        io_keyHash            = rand_vec();
        io_source_bits_msg    = rand_vec();
        io_source_bits_verify = 1'b1;
        io_source_valid       = 1'b1;
        io_pad_req_ready      = 1'b0;
        @(negedge clock);
        io_source_valid = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        checks++; if (io_source_ready !== 1'b1) begin errors++; $display("FAIL midrst_source_ready: got %b want 1", io_source_ready); end
        checks++; if (io_pad_req_valid !== 1'b0) begin errors++; $display("FAIL midrst_req_valid: got %b want 0", io_pad_req_valid); end
        checks++; if (io_tag_valid !== 1'b0) begin errors++; $display("FAIL midrst_tag_valid: got %b want 0", io_tag_valid); end
        checks++; if (io_tag_bits !== '0) begin errors++; $display("FAIL midrst_tag_bits: got %h want 0", io_tag_bits); end
        checks++; if (io_tag_match !== 1'b0) begin errors++; $display("FAIL midrst_tag_match: got %b want 0", io_tag_match); end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        m = rand_vec(); k = rand_vec(); pad = {$urandom, $urandom};
        do_txn(m, k, 1'b0, '0, pad, 1, 4, 0, 1'b0);
        checks++; if (r_tag !== ref_tag(m, k, pad)) begin errors++; $display("FAIL midrst_fresh_tag: got %h want %h", r_tag, ref_tag(m, k, pad)); end
        checks++; if (r_fires !== 1) begin errors++; $display("FAIL midrst_req_fires: got %0d want 1", r_fires); end
    endtask

    task automatic test_random();
        logic [MSG_W-1:0] m;
        logic [MSG_W-1:0] k;
        logic [63:0]      pad;
        logic [TAG_W-1:0] want;
        logic [TAG_W-1:0] et;
        logic             vfy;
        int               rh;
        int               pg;
        int               th;
        for (int it = 0; it < 10; it++) begin
            m = rand_vec(); k = rand_vec(); pad = {$urandom, $urandom};
            want = ref_tag(m, k, pad);
            vfy  = 1'($urandom_range(0, 1));
            et   = ($urandom_range(0, 1) == 1) ? want : (want ^ TAG_W'(64'd1 << $urandom_range(0, TAG_W - 1)));
            rh = $urandom_range(0, 4);
            pg = $urandom_range(1, 12);
            th = $urandom_range(0, 3);
            do_txn(m, k, vfy, et, pad, rh, pg, th, 1'($urandom_range(0, 1)));
            checks++; if (r_tag !== want) begin errors++; $display("FAIL rand%0d_tag: got %h want %h", it, r_tag, want); end
            checks++; if (r_match !== (vfy && (et == want))) begin errors++; $display("FAIL rand%0d_match: got %b want %b", it, r_match, vfy && (et == want)); end
            checks++; if (r_vc !== max2(N, r_pc) + 1) begin errors++; $display("FAIL rand%0d_latency: got %0d want %0d", it, r_vc, max2(N, r_pc) + 1); end
            checks++; if (r_fires !== 1) begin errors++; $display("FAIL rand%0d_req_fires: got %0d want 1", it, r_fires); end
        end
    endtask

    initial begin
        test_reset();
        test_zero_msg_pad();
        test_small_words();
        test_wrap_verify();
        test_req_stall();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
